// File: rtl/contra_pkg.sv
// -----------------------------------------------------------------------------
// contra_pkg
//   Definitions shared by the per-pixel sprite layers of the compositor.
//
//   Contents:
//     SCREEN_W / SCREEN_H : visible raster size in pixels (640x480)
//     coord_t             : 10-bit screen coordinate
//     bullet_state_t      : life cycle of the player's bullet
//     zext11()            : widen a coordinate to 11 bits so that bound sums
//                           (origin + size + speed) can never wrap
// -----------------------------------------------------------------------------
package contra_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef logic [9:0] coord_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LAUNCH   = 2'd1,
        ST_FLYING   = 2'd2,
        ST_COOLDOWN = 2'd3
    } bullet_state_t;

    // Zero-extend a screen coordinate into the 11-bit comparison domain.
    function automatic logic [10:0] zext11(input coord_t v);
        return {1'b0, v};
    endfunction

endpackage : contra_pkg

// File: rtl/rect_hit.sv
// -----------------------------------------------------------------------------
// rect_hit
//   Registered point-in-square test. One cycle after a point is presented,
//   `hit` reports whether it lies inside [boxX, boxX+SIZE) x [boxY, boxY+SIZE)
//   while `enable` is high. Meant to be shared by every sprite layer that
//   needs a box hit against the raster position.
//
//   Parameters:
//     SIZE    : box edge length in pixels
//   Ports:
//     Clk     in  1  : clock
//     Reset   in  1  : asynchronous, active-high
//     enable  in  1  : qualifies the test (box currently drawn)
//     pointX  in  10 : point under test, x
//     pointY  in  10 : point under test, y
//     boxX    in  10 : box origin (top-left), x
//     boxY    in  10 : box origin (top-left), y
//     hit     out 1  : registered result
// -----------------------------------------------------------------------------
module rect_hit #(
    parameter int SIZE = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       enable,
    input  logic [9:0] pointX,
    input  logic [9:0] pointY,
    input  logic [9:0] boxX,
    input  logic [9:0] boxY,
    output logic       hit
);
    import contra_pkg::*;

    localparam logic [10:0] SIZE_W = 11'(SIZE);

    logic [10:0] x_end_s;
    logic [10:0] y_end_s;
    logic        in_x_s;
    logic        in_y_s;

    // Half-open interval tests; the far edge is computed in 11 bits so a box
    // near coordinate 1023 does not wrap to a small value.
    always_comb begin
        x_end_s = zext11(boxX) + SIZE_W;
        y_end_s = zext11(boxY) + SIZE_W;
        in_x_s  = (zext11(pointX) >= zext11(boxX)) && (zext11(pointX) < x_end_s);
        in_y_s  = (zext11(pointY) >= zext11(boxY)) && (zext11(pointY) < y_end_s);
    end

    // Result register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hit <= 1'b0;
        end else begin
            hit <= enable && in_x_s && in_y_s;
        end
    end

endmodule : rect_hit

// File: rtl/bullet_logic.sv
// -----------------------------------------------------------------------------
// bullet_logic
//   Owns the player's single bullet: fire request, one-cycle launch, per-frame
//   horizontal motion, off-screen retirement and a frame-counted cooldown.
//   Every cycle the raster position is tested against the bullet box and the
//   registered result is handed to the pixel compositor (bulletOn1 appears one
//   cycle after DrawX/DrawY; the compositor adds its own cycle).
//
//   Build option:
//     BULLET_AUTOFIRE_EN : when defined, a held `fire` relaunches on the first
//                          IDLE cycle after cooldown. When undefined, every
//                          shot needs `fire` to be seen low and then high.
//
//   Parameters:
//     SCREEN_W, SCREEN_H  : visible raster size
//     BULLET_SIZE         : bullet square edge
//     BULLET_SPEED        : pixels moved per frameTick
//     MUZZLE_DX/MUZZLE_DY : launch offset from the player's top-left
//     COOLDOWN_FRAMES     : frameTicks between retirement and the next launch
//                           (counter is 8 bits wide, so at most 255)
//   Ports:
//     Clk          in  1  : clock
//     Reset        in  1  : asynchronous, active-high
//     frameTick    in  1  : one-cycle pulse per frame
//     fire         in  1  : level fire request
//     facingLeft   in  1  : player direction, sampled at launch only
//     playerX/Y    in  10 : player sprite top-left
//     DrawX/DrawY  in  10 : current raster pixel
//     bulletOn1    out 1  : raster pixel inside the flying bullet (registered)
//     bulletActive out 1  : bullet in LAUNCH or FLYING (registered)
//     fireAck      out 1  : one-cycle pulse on LAUNCH entry (registered)
// -----------------------------------------------------------------------------
module bullet_logic #(
    parameter int SCREEN_W        = 640,
    parameter int SCREEN_H        = 480,
    parameter int BULLET_SIZE     = 4,
    parameter int BULLET_SPEED    = 4,
    parameter int MUZZLE_DX       = 16,
    parameter int MUZZLE_DY       = 8,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frameTick,
    input  logic       fire,
    input  logic       facingLeft,
    input  logic [9:0] playerX,
    input  logic [9:0] playerY,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic       bulletOn1,
    output logic       bulletActive,
    output logic       fireAck
);
    import contra_pkg::*;

    // Constants in the widths they are used at.
    localparam logic [10:0] SCREEN_W_W = 11'(SCREEN_W);
    localparam logic [10:0] SCREEN_H_W = 11'(SCREEN_H);
    localparam logic [10:0] SIZE_W     = 11'(BULLET_SIZE);
    localparam logic [10:0] SPEED_W    = 11'(BULLET_SPEED);
    localparam logic [10:0] MDX_W      = 11'(MUZZLE_DX);
    localparam logic [9:0]  SPEED_C    = 10'(BULLET_SPEED);
    localparam logic [9:0]  MDX_C      = 10'(MUZZLE_DX);
    localparam logic [9:0]  MDY_C      = 10'(MUZZLE_DY);
    localparam logic [7:0]  COOL_C     = 8'(COOLDOWN_FRAMES);

    bullet_state_t state_r;
    bullet_state_t state_next_s;
    coord_t        bx_r;
    coord_t        by_r;
    coord_t        bx_next_s;
    coord_t        by_next_s;
    logic          dir_left_r;
    logic          dir_left_next_s;
    logic [7:0]    cnt_r;
    logic [7:0]    cnt_next_s;
    logic          armed_r;
    logic          launch_s;
    logic          flying_s;

    logic [10:0]   right_reach_s;
    logic [10:0]   bottom_reach_s;
    coord_t        muzzle_right_s;
    coord_t        muzzle_left_s;

    // Bound and muzzle arithmetic. Right/bottom reaches are 11 bits so the
    // off-screen test cannot be fooled by a wrapped sum. The right muzzle is
    // plain 10-bit addition: a player that far right is off-screen anyway.
    always_comb begin
        right_reach_s  = zext11(bx_r) + SPEED_W + SIZE_W;
        bottom_reach_s = zext11(by_r) + SIZE_W;
        muzzle_right_s = playerX + MDX_C;
        if (zext11(playerX) < MDX_W) begin
            muzzle_left_s = 10'd0;
        end else begin
            muzzle_left_s = playerX - MDX_C;
        end
    end

    // Launch qualifier: only from IDLE, and only while armed.
    always_comb begin
        launch_s = (state_r == ST_IDLE) && fire && armed_r;
        flying_s = (state_r == ST_FLYING);
    end

    // Next-state, position, direction and cooldown counter.
    always_comb begin
        state_next_s    = state_r;
        bx_next_s       = bx_r;
        by_next_s       = by_r;
        dir_left_next_s = dir_left_r;
        cnt_next_s      = cnt_r;
        case (state_r)
            ST_IDLE: begin
                // A simultaneous frameTick is simply not looked at here.
                if (launch_s) begin
                    state_next_s = ST_LAUNCH;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                // Ticks during LAUNCH are dropped; motion starts in FLYING.
                dir_left_next_s = facingLeft;
                by_next_s       = playerY + MDY_C;
                if (facingLeft) begin
                    bx_next_s = muzzle_left_s;
                end else begin
                    bx_next_s = muzzle_right_s;
                end
                state_next_s = ST_FLYING;
            end
            ST_FLYING: begin
                if (frameTick) begin
                    if (bottom_reach_s > SCREEN_H_W) begin
                        // Launched below the visible area: gone at first tick.
                        state_next_s = ST_COOLDOWN;
                        cnt_next_s   = COOL_C;
                    end else if (dir_left_r) begin
                        if (zext11(bx_r) < SPEED_W) begin
                            state_next_s = ST_COOLDOWN;
                            cnt_next_s   = COOL_C;
                        end else begin
                            bx_next_s = bx_r - SPEED_C;
                        end
                    end else begin
                        if (right_reach_s > SCREEN_W_W) begin
                            state_next_s = ST_COOLDOWN;
                            cnt_next_s   = COOL_C;
                        end else begin
                            bx_next_s = bx_r + SPEED_C;
                        end
                    end
                end else begin
                    state_next_s = ST_FLYING;
                end
            end
            ST_COOLDOWN: begin
                if (cnt_r == 8'd0) begin
                    // Only reachable with a zero cooldown setting.
                    state_next_s = ST_IDLE;
                end else if (frameTick) begin
                    cnt_next_s = cnt_r - 8'd1;
                    if (cnt_r == 8'd1) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_COOLDOWN;
                    end
                end else begin
                    state_next_s = ST_COOLDOWN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State and bullet registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r    <= ST_IDLE;
            bx_r       <= 10'd0;
            by_r       <= 10'd0;
            dir_left_r <= 1'b0;
            cnt_r      <= 8'd0;
        end else begin
            state_r    <= state_next_s;
            bx_r       <= bx_next_s;
            by_r       <= by_next_s;
            dir_left_r <= dir_left_next_s;
            cnt_r      <= cnt_next_s;
        end
    end

    // Re-arm logic: decides whether a held fire button may relaunch.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            armed_r <= 1'b1;
        end else begin
`ifdef BULLET_AUTOFIRE_EN
            armed_r <= 1'b1;
`else
            if (launch_s) begin
                armed_r <= 1'b0;
            end else if (!fire) begin
                armed_r <= 1'b1;
            end else begin
                armed_r <= armed_r;
            end
`endif
        end
    end

    // Status outputs, registered from the next-state decode so they line up
    // with the state they describe.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bulletActive <= 1'b0;
            fireAck      <= 1'b0;
        end else begin
            bulletActive <= (state_next_s == ST_LAUNCH) || (state_next_s == ST_FLYING);
            fireAck      <= launch_s;
        end
    end

    // Raster hit against the current bullet box, only while it is flying.
    rect_hit #(
        .SIZE (BULLET_SIZE)
    ) u_hit (
        .Clk    (Clk),
        .Reset  (Reset),
        .enable (flying_s),
        .pointX (DrawX),
        .pointY (DrawY),
        .boxX   (bx_r),
        .boxY   (by_r),
        .hit    (bulletOn1)
    );

endmodule : bullet_logic

// File: tb/tb_bullet_logic.sv
// -----------------------------------------------------------------------------
// tb_bullet_logic
//   Scoreboard bench for bullet_logic. A driver applies inputs on the falling
//   edge, advances a behavioural model of the bullet and pushes the outputs
//   expected after the next rising edge; a monitor pops and compares shortly
//   after each rising edge.
// -----------------------------------------------------------------------------
module tb_bullet_logic;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frameTick;
    logic       fire;
    logic       facingLeft;
    logic [9:0] playerX;
    logic [9:0] playerY;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       bulletOn1;
    logic       bulletActive;
    logic       fireAck;

    bullet_logic dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frameTick    (frameTick),
        .fire         (fire),
        .facingLeft   (facingLeft),
        .playerX      (playerX),
        .playerY      (playerY),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .bulletOn1    (bulletOn1),
        .bulletActive (bulletActive),
        .fireAck      (fireAck)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic on;
        logic act;
        logic ack;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: where the bullet is and what phase of its life.
    localparam int PH_IDLE = 0, PH_LAUNCH = 1, PH_FLY = 2, PH_COOL = 3;
    int m_ph;
    int m_bx;
    int m_by;
    int m_left;
    int m_frames_left;
    int m_armed;

    task automatic check(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %0b, expected %0b", name, $time, got, want);
        end
    endtask

    function automatic void model_reset();
        m_ph = PH_IDLE; m_bx = 0; m_by = 0; m_left = 0;
        m_frames_left = 0; m_armed = 1;
    endfunction

    function automatic void retire();
        m_ph = PH_COOL;
        m_frames_left = 8;
    endfunction

    // One clock edge of the model using the inputs currently driven.
    function automatic void model_step();
        exp_t e;
        int   launched;
        int   dx, dy;
        dx = int'(DrawX);
        dy = int'(DrawY);
        launched = 0;
        e.on  = (m_ph == PH_FLY) && dx >= m_bx && dx < m_bx + 4 && dy >= m_by && dy < m_by + 4;
        e.ack = 1'b0;
        case (m_ph)
            PH_IDLE: if (fire && m_armed != 0) begin
                m_ph = PH_LAUNCH; e.ack = 1'b1; launched = 1;
            end
            PH_LAUNCH: begin
                m_left = int'(facingLeft);
                m_by   = (int'(playerY) + 8) % 1024;
                if (m_left != 0) m_bx = (int'(playerX) < 16) ? 0 : int'(playerX) - 16;
                else             m_bx = (int'(playerX) + 16) % 1024;
                m_ph = PH_FLY;
            end
            PH_FLY: if (frameTick) begin
                if (m_by + 4 > 480)      retire();
                else if (m_left != 0) begin
                    if (m_bx < 4) retire(); else m_bx -= 4;
                end else begin
                    if (m_bx + 8 > 640) retire(); else m_bx += 4;
                end
            end
            default: if (frameTick) begin
                m_frames_left--;
                if (m_frames_left == 0) m_ph = PH_IDLE;
            end
        endcase
`ifdef BULLET_AUTOFIRE_EN
        m_armed = 1;
`else
        if (launched != 0) m_armed = 0;
        else if (!fire)    m_armed = 1;
`endif
        e.act = (m_ph == PH_LAUNCH) || (m_ph == PH_FLY);
        sb_q.push_back(e);
    endfunction

    task automatic drive(input logic f, input logic t, input logic fl,
                         input int px, input int py, input int dx, input int dy);
        @(negedge Clk);
        fire = f; frameTick = t; facingLeft = fl;
        playerX = 10'(px); playerY = 10'(py); DrawX = 10'(dx); DrawY = 10'(dy);
        model_step();
    endtask

    // Idle cycles with ticks until the model bullet is back in IDLE.
    task automatic settle();
        for (int i = 0; i < 200 && m_ph != PH_IDLE; i++)
            drive(1'b0, 1'(i % 2), 1'b0, 100, 200, m_bx, m_by);
    endtask

    task automatic apply_reset();
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        check("reset_bulletOn1", bulletOn1, 1'b0);
        check("reset_bulletActive", bulletActive, 1'b0);
        check("reset_fireAck", fireAck, 1'b0);
        sb_q.delete();
        model_reset();
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Monitor: compare the expected outputs for the edge just taken.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (!Reset && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("bulletOn1", bulletOn1, e.on);
                check("bulletActive", bulletActive, e.act);
                check("fireAck", fireAck, e.ack);
            end
        end
    end

    initial begin
        int px, py, r;
        logic f;
        Reset = 1'b1; fire = 1'b0; frameTick = 1'b0; facingLeft = 1'b0;
        playerX = 10'd0; playerY = 10'd0; DrawX = 10'd0; DrawY = 10'd0;
        model_reset();
        apply_reset();

        // Basic launch at (100,200) facing right and raster probes at (116,208).
        drive(1'b1, 1'b0, 1'b0, 100, 200, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 100, 200, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 100, 200, 116, 208);
        drive(1'b0, 1'b0, 1'b0, 100, 200, 119, 208);
        drive(1'b0, 1'b0, 1'b0, 100, 200, 120, 208);
        drive(1'b0, 1'b0, 1'b0, 100, 200, 116, 212);
        drive(1'b0, 1'b0, 1'b0, 100, 200, 115, 211);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 100, 200, 0, 0);
            drive(1'b0, 1'b0, 1'b0, 100, 200, 0, 0);
        end
        drive(1'b0, 1'b0, 1'b0, 100, 200, 128, 208);
        drive(1'b0, 1'b0, 1'b0, 100, 200, 127, 208);
        drive(1'b0, 1'b0, 1'b0, 100, 200, 131, 211);
        settle();

        // Right edge: muzzle at 632, one step to 636, then retirement.
        drive(1'b1, 1'b0, 1'b0, 616, 100, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 616, 100, 0, 0);
        drive(1'b0, 1'b1, 1'b0, 616, 100, 632, 108);
        drive(1'b0, 1'b0, 1'b0, 616, 100, 636, 108);
        drive(1'b0, 1'b1, 1'b0, 616, 100, 639, 111);
        drive(1'b0, 1'b0, 1'b0, 616, 100, 636, 108);

        // Cooldown with fire held: no relaunch without release (or autofire).
        for (int i = 0; i < 40; i++)
            drive(1'b1, 1'(i % 3 == 0), 1'b0, 300, 100, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 300, 100, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 300, 100, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 300, 100, 0, 0);
        settle();

        // Left edge: muzzle at 3, first tick retires.
        drive(1'b1, 1'b0, 1'b1, 19, 50, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 19, 50, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 19, 50, 3, 58);
        drive(1'b0, 1'b1, 1'b0, 19, 50, 6, 61);
        drive(1'b0, 1'b0, 1'b0, 19, 50, 3, 58);
        settle();

        // Left launch near x=0 clamps the muzzle to 0.
        drive(1'b1, 1'b0, 1'b1, 5, 60, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 5, 60, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 5, 60, 0, 68);
        drive(1'b0, 1'b0, 1'b0, 5, 60, 3, 71);
        settle();

        // Fire and tick together in IDLE, tick during LAUNCH: no motion yet.
        drive(1'b1, 1'b1, 1'b0, 200, 300, 0, 0);
        drive(1'b0, 1'b1, 1'b0, 200, 300, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 200, 300, 216, 308);
        drive(1'b0, 1'b0, 1'b0, 200, 300, 220, 308);
        settle();

        // Launched below the bottom edge: first tick retires.
        drive(1'b1, 1'b0, 1'b0, 200, 474, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 200, 474, 0, 0);
        drive(1'b0, 1'b1, 1'b0, 200, 474, 216, 482);
        drive(1'b0, 1'b0, 1'b0, 200, 474, 216, 482);
        settle();

        // Reset in flight, then fire again.
        drive(1'b1, 1'b0, 1'b0, 100, 100, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 100, 100, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 100, 100, 116, 108);
        apply_reset();
        drive(1'b1, 1'b0, 1'b0, 100, 100, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 100, 100, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 100, 100, 116, 108);

        // Randomized traffic with raster probes clustered on the bullet.
        f = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 9) == 0) f = ~f;
            r = int'($urandom_range(0, 3));
            if (r == 0)      px = int'($urandom_range(0, 30));
            else if (r == 1) px = int'($urandom_range(600, 639));
            else             px = int'($urandom_range(0, 639));
            py = ($urandom_range(0, 7) == 0) ? int'($urandom_range(466, 479))
                                             : int'($urandom_range(0, 479));
            drive(f, 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), px, py,
                  m_bx + int'($urandom_range(0, 6)) - 1,
                  m_by + int'($urandom_range(0, 6)) - 1);
        end

        repeat (3) @(negedge Clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_bullet_logic
